// File: rtl/mul8_arb4_if.sv
// rtl/mul8_arb4_if.sv - request/response bundle for the four-way shared multiplier arbiter
//   req_valid[3:0]  requester -> arbiter  per-requester operation request
//   req_ready[3:0]  arbiter -> requester  one-hot accept strobe
//   req_a/req_b     requester -> arbiter  packed operands, requester i at [8i+7:8i]
//   rsp_valid       arbiter -> consumer   result available
//   rsp_ready       consumer -> arbiter   result accept
//   rsp_id          arbiter -> consumer   owning requester index
//   rsp_p           arbiter -> consumer   registered product
interface mul8_arb4_if;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_p;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );
endinterface

// File: rtl/mul8_arb4.sv
// rtl/mul8_arb4.sv - round-robin arbiter sharing one 8x8 approximate multiplier among four requesters
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   bus      mul8_arb4_if.slave: request/grant and response handshakes
//   mul_a    operand A to the shared multiplier (held between operations)
//   mul_b    operand B to the shared multiplier
//   mul_o    combinational product from the shared multiplier
//   err_clr  synchronous clear of err_acc
//   err_acc  accumulated absolute error vs exact product
// Optional feature: define MUL8_ARB_ERRMON_EN to build the error monitor;
// otherwise err_acc is constant zero and err_clr is ignored.
module mul8_arb4 #(
    parameter int CALC_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mul8_arb4_if.slave        bus,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_o,
    input  logic              err_clr,
    output logic [23:0]       err_acc
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [1:0] CNT_INIT = 2'(CALC_CYC - 1);

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  op_a_q, op_a_d;
    logic [7:0]  op_b_q, op_b_d;
    logic [15:0] rsp_p_q, rsp_p_d;
    logic [1:0]  rsp_id_q, rsp_id_d;
    logic [1:0]  cnt_q, cnt_d;
    // Low for the first cycle after reset release so no grant is issued then.
    logic        armed_q, armed_d;

    logic        gnt_found;
    logic [1:0]  gnt_idx;
    logic [1:0]  idx;
    logic [3:0]  req_ready_c;
    logic        capture;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        cnt_d       = cnt_q;
        armed_d     = 1'b1;
        req_ready_c = 4'b0000;
        capture     = 1'b0;
        gnt_found   = 1'b0;
        gnt_idx     = ptr_q;
        idx         = ptr_q;

        // First valid requester at or after ptr, wrapping mod 4.
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (armed_q && gnt_found) begin
                    req_ready_c[gnt_idx] = 1'b1;
                    op_a_d   = bus.req_a[{gnt_idx, 3'b000} +: 8];
                    op_b_d   = bus.req_b[{gnt_idx, 3'b000} +: 8];
                    rsp_id_d = gnt_idx;
                    ptr_d    = gnt_idx + 2'd1;
                    cnt_d    = CNT_INIT;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q == 2'd0) begin
                    rsp_p_d = mul_o;
                    capture = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            op_a_q   <= 8'd0;
            op_b_q   <= 8'd0;
            rsp_p_q  <= 16'd0;
            rsp_id_q <= 2'd0;
            cnt_q    <= 2'd0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            rsp_p_q  <= rsp_p_d;
            rsp_id_q <= rsp_id_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_p     = rsp_p_q;
    assign mul_a         = op_a_q;
    assign mul_b         = op_b_q;

`ifdef MUL8_ARB_ERRMON_EN
    logic [15:0] exact_p;
    logic [15:0] abs_err;
    logic [24:0] err_sum;
    logic [23:0] err_acc_q, err_acc_d;

    always_comb begin
        exact_p   = op_a_q * op_b_q;
        abs_err   = (mul_o >= exact_p) ? (mul_o - exact_p) : (exact_p - mul_o);
        err_sum   = {1'b0, err_acc_q} + {9'd0, abs_err};
        err_acc_d = err_acc_q;
        // Clear has priority over an add landing in the same cycle.
        if (err_clr) begin
            err_acc_d = 24'd0;
        end else if (capture) begin
            err_acc_d = err_sum[24] ? 24'hFFFFFF : err_sum[23:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc_q <= 24'd0;
        end else begin
            err_acc_q <= err_acc_d;
        end
    end

    assign err_acc = err_acc_q;
`else
    logic unused_errmon;
    assign unused_errmon = err_clr ^ capture;
    assign err_acc       = 24'd0;
`endif

endmodule
